// File: rtl/soc_pkg.sv
// Shared constants and helpers for the data-SRAM responder: confreg offsets,
// default confreg window base and the byte-lane merge rule.
package soc_pkg;

    localparam logic [31:0] CONF_BASE_DEFAULT = 32'hbfaf_0000;

    localparam logic [15:0] CR_TIMER   = 16'he000;
    localparam logic [15:0] CR_LED     = 16'hf000;
    localparam logic [15:0] CR_NUM     = 16'hf010;
    localparam logic [15:0] CR_SWITCH  = 16'hf020;
    localparam logic [15:0] CR_SCRATCH = 16'hf030;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dsram_confreg_resp_if.sv
// CPU data-SRAM port bundle: request fields from the CPU, read data back.
interface dsram_confreg_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/bram_be.sv
// Single-port read-first synchronous RAM with byte write enables; no reset,
// output holds while en is low.
module bram_be
    import soc_pkg::*;
#(
    parameter int RAM_AW = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        wen,
    input  logic [RAM_AW-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_r [0:(2**RAM_AW)-1];

    // Read old contents and apply the byte-masked write on the same edge.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem_r[addr];
            if (wen != 4'b0000) begin
                mem_r[addr] <= byte_merge(mem_r[addr], wdata, wen);
            end
        end
    end

endmodule

// File: rtl/dsram_confreg_resp.sv
// Data-SRAM responder: word RAM plus a confreg window (TIMER, LED, NUM,
// SWITCH, SCRATCH), both answering with one-cycle read latency.
module dsram_confreg_resp
    import soc_pkg::*;
#(
    parameter int          RAM_AW    = 12,
    parameter logic [31:0] CONF_BASE = CONF_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    dsram_confreg_resp_if.slave   sram,
    input  logic [7:0]            switch,
    output logic [15:0]           led,
    output logic [31:0]           num_data
);

    logic        conf_hit_s;
    logic [15:0] offset_s;
    logic        ram_en_s;
    logic        conf_wr_s;
    logic [31:0] conf_rd_s;
    logic [31:0] merged_s;
    logic [31:0] ram_dout_s;

    logic [31:0] timer_r;
    logic [15:0] led_r;
    logic [31:0] num_r;
    logic [31:0] scratch_r;
    logic [7:0]  switch_r;
    logic        conf_hit_q;
    logic [31:0] conf_rdata_r;

    assign conf_hit_s = (sram.data_sram_addr[31:16] == CONF_BASE[31:16]);
    assign offset_s   = sram.data_sram_addr[15:0];
    assign ram_en_s   = sram.data_sram_en & ~conf_hit_s;

    // Current confreg value at the addressed offset; also the old word for merges.
    always_comb begin
        conf_rd_s = 32'h0000_0000;
        case (offset_s)
            CR_TIMER:   conf_rd_s = timer_r;
            CR_LED:     conf_rd_s = {16'h0000, led_r};
            CR_NUM:     conf_rd_s = num_r;
            CR_SWITCH:  conf_rd_s = {24'h00_0000, switch_r};
            CR_SCRATCH: conf_rd_s = scratch_r;
            default:    conf_rd_s = 32'h0000_0000;
        endcase
        conf_wr_s = sram.data_sram_en & conf_hit_s & (sram.data_sram_wen != 4'b0000);
        merged_s  = byte_merge(conf_rd_s, sram.data_sram_wdata, sram.data_sram_wen);
    end

    // Confreg state, timer, switch sampler and the registered confreg read path.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r      <= 32'h0000_0000;
            led_r        <= 16'h0000;
            num_r        <= 32'h0000_0000;
            scratch_r    <= 32'h0000_0000;
            switch_r     <= 8'h00;
            // Selecting the cleared confreg path makes rdata read 0 out of reset.
            conf_hit_q   <= 1'b1;
            conf_rdata_r <= 32'h0000_0000;
        end else begin
            switch_r <= switch;
            if (conf_wr_s && (offset_s == CR_TIMER)) begin
                timer_r <= merged_s;
            end else begin
                timer_r <= timer_r + 32'd1;
            end
            if (sram.data_sram_en) begin
                conf_hit_q <= conf_hit_s;
                if (conf_hit_s) begin
                    conf_rdata_r <= conf_rd_s;
                end
            end
            if (conf_wr_s) begin
                case (offset_s)
                    CR_LED:     led_r     <= merged_s[15:0];
                    CR_NUM:     num_r     <= merged_s;
                    CR_SCRATCH: scratch_r <= merged_s;
                    default:    ;
                endcase
            end
        end
    end

    bram_be #(.RAM_AW(RAM_AW)) u_ram (
        .clk   (clk),
        .en    (ram_en_s),
        .wen   (sram.data_sram_wen),
        .addr  (sram.data_sram_addr[RAM_AW+1:2]),
        .wdata (sram.data_sram_wdata),
        .rdata (ram_dout_s)
    );

    assign sram.data_sram_rdata = conf_hit_q ? conf_rdata_r : ram_dout_s;
    assign led                  = led_r;
    assign num_data             = num_r;

endmodule
